if_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the SPARC IF stage. Drives PC/nPC load enables, the nPC

---
 rtl/if_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer for the SPARC IF stage: PC/nPC load enables, nPC source select,
// IF/ID load/flush, boot hold, imem wait tracking and delay-slot annulment.
module if_fetch_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int MAX_WAIT    = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             R,
    input  logic             imem_ready,
    input  logic             stall_in,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic             br_always,
    input  logic             br_annul,
    input  logic             jmpl_valid,
    output logic             pc_le,
    output logic             npc_le,
    output logic [1:0]       npc_sel,
    output logic             ifid_le,
    output logic             ifid_flush,
    output logic             id_freeze,
    output logic             fetch_valid,
    output logic [1:0]       state,
    output logic             imem_timeout,
    output logic [CNT_W-1:0] redirect_count
);

    localparam int BOOT_EFF = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;
    localparam int WAIT_EFF = (MAX_WAIT < 1) ? 1 : MAX_WAIT;
    localparam int BOOT_W   = (BOOT_EFF > 1) ? $clog2(BOOT_EFF) : 1;
    localparam int WAIT_W   = $clog2(WAIT_EFF + 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10,
        ST_HOLD = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [BOOT_W-1:0]  boot_cnt_q, boot_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   redir_q, redir_d;
    logic               redirect;

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            redir_q    <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            redir_q    <= redir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        redir_d    = redir_q;
        redirect   = 1'b0;
        pc_le      = 1'b0;
        npc_le     = 1'b0;
        npc_sel    = 2'b00;
        ifid_le    = 1'b1;
        ifid_flush = 1'b1;
        id_freeze  = 1'b0;

        if (imem_ready) begin
            wait_cnt_d = '0;
        end

        if (state_q == ST_BOOT) begin
            boot_cnt_d = boot_cnt_q + 1'b1;
            if (boot_cnt_q == BOOT_W'(BOOT_EFF - 1)) begin
                state_d = ST_RUN;
            end
        end else begin
            ifid_flush = 1'b0;
            if (!imem_ready) begin
                ifid_le   = 1'b0;
                id_freeze = 1'b1;
                state_d   = ST_WAIT;
                if (wait_cnt_q != WAIT_W'(WAIT_EFF)) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                if (wait_cnt_q == WAIT_W'(WAIT_EFF - 1)) begin
                    timeout_d = 1'b1;
                end
            end else if (stall_in) begin
                // CTI in ID stays unresolved; hazard unit re-presents it after the stall.
                ifid_le = 1'b0;
                state_d = ST_HOLD;
            end else begin
                pc_le   = 1'b1;
                npc_le  = 1'b1;
                state_d = ST_RUN;
                if (jmpl_valid) begin
                    npc_sel  = 2'b10;
                    redirect = 1'b1;
                end else if (br_valid && br_taken) begin
                    npc_sel  = 2'b01;
                    redirect = 1'b1;
                end
                // Annul squashes the delay slot unless the branch is taken conditionally.
                ifid_flush = !jmpl_valid && br_valid && br_annul && (!br_taken || br_always);
            end
        end

        if (redirect && !(&redir_q)) begin
            redir_d = redir_q + 1'b1;
        end
    end

    assign fetch_valid    = ifid_le & ~ifid_flush;
    assign state          = state_q;
    assign imem_timeout   = timeout_q;
    assign redirect_count = redir_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: a behavioural model predicts each cycle's
// outputs into a queue, and a negedge monitor compares them against the DUT.
module tb_if_fetch_ctrl;

    localparam int BOOT_CYCLES = 2;
    localparam int MAX_WAIT    = 4;
    localparam int CNT_W       = 5;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    localparam int BOOT_EFF    = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;

    logic             clk = 1'b0;
    logic             R = 1'b0;
    logic             imem_ready = 1'b1;
    logic             stall_in = 1'b0;
    logic             br_valid = 1'b0;
    logic             br_taken = 1'b0;
    logic             br_always = 1'b0;
    logic             br_annul = 1'b0;
    logic             jmpl_valid = 1'b0;
    logic             pc_le, npc_le, ifid_le, ifid_flush, id_freeze, fetch_valid, imem_timeout;
    logic [1:0]       npc_sel, state;
    logic [CNT_W-1:0] redirect_count;

    if_fetch_ctrl #(
        .BOOT_CYCLES(BOOT_CYCLES),
        .MAX_WAIT   (MAX_WAIT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .R             (R),
        .imem_ready    (imem_ready),
        .stall_in      (stall_in),
        .br_valid      (br_valid),
        .br_taken      (br_taken),
        .br_always     (br_always),
        .br_annul      (br_annul),
        .jmpl_valid    (jmpl_valid),
        .pc_le         (pc_le),
        .npc_le        (npc_le),
        .npc_sel       (npc_sel),
        .ifid_le       (ifid_le),
        .ifid_flush    (ifid_flush),
        .id_freeze     (id_freeze),
        .fetch_valid   (fetch_valid),
        .state         (state),
        .imem_timeout  (imem_timeout),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pcLe, npcLe, npcSel, ifidLe, ifidFlush, idFreeze, fetchValid, st, timeout, redir;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   cycleNum   = 0;

    // Reference model: mode 0 BOOT, 1 RUN, 2 WAIT, 3 HOLD
    int mMode, mBoot, mWait, mTimeout, mRedir;
    bit cR, cImr, cSt, cBv, cBt, cBa, cBan, cJv;

    task automatic modelReset();
        mMode = 0; mBoot = 0; mWait = 0; mTimeout = 0; mRedir = 0;
    endtask

    task automatic modelStep();
        if (mMode == 0) begin
            mBoot++;
            if (mBoot >= BOOT_EFF) mMode = 1;
        end else if (!cImr) begin
            mMode = 2;
            if (mWait + 1 >= MAX_WAIT) mTimeout = 1;
            if (mWait < MAX_WAIT) mWait++;
        end else if (cSt) begin
            mMode = 3;
        end else begin
            mMode = 1;
            if ((cJv || (cBv && cBt)) && mRedir < CNT_MAX) mRedir++;
        end
        if (cImr) mWait = 0;
    endtask

    function automatic exp_t modelOutputs();
        exp_t e;
        e.pcLe = 0; e.npcLe = 0; e.npcSel = 0; e.ifidLe = 0; e.ifidFlush = 0; e.idFreeze = 0;
        e.st = mMode; e.timeout = mTimeout; e.redir = mRedir;
        if (mMode == 0) begin
            e.ifidLe = 1; e.ifidFlush = 1;
        end else if (!cImr) begin
            e.idFreeze = 1;
        end else if (!cSt) begin
            e.pcLe = 1; e.npcLe = 1; e.ifidLe = 1;
            e.npcSel = cJv ? 2 : ((cBv && cBt) ? 1 : 0);
            e.ifidFlush = (!cJv && cBv && cBan && (!cBt || cBa)) ? 1 : 0;
        end
        e.fetchValid = (e.ifidLe == 1 && e.ifidFlush == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic applyStimulus(input bit r, input bit imr, input bit st, input bit bv,
                                 input bit bt, input bit ba, input bit ban, input bit jv);
        @(posedge clk);
        if (cR) modelStep();
        #1;
        cR = r; cImr = imr; cSt = st; cBv = bv; cBt = bt; cBa = ba; cBan = ban; cJv = jv;
        R = r; imem_ready = imr; stall_in = st; br_valid = bv; br_taken = bt;
        br_always = ba; br_annul = ban; jmpl_valid = jv;
        if (!r) modelReset();
        expQ.push_back(modelOutputs());
    endtask

    task automatic checkField(input string name, input int act, input int req);
        checkCount++;
        if (act == req) passCount++;
        else $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, cycleNum, act, req);
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("pc_le", int'(pc_le), e.pcLe);
        checkField("npc_le", int'(npc_le), e.npcLe);
        checkField("npc_sel", int'(npc_sel), e.npcSel);
        checkField("ifid_le", int'(ifid_le), e.ifidLe);
        checkField("ifid_flush", int'(ifid_flush), e.ifidFlush);
        checkField("id_freeze", int'(id_freeze), e.idFreeze);
        checkField("fetch_valid", int'(fetch_valid), e.fetchValid);
        checkField("state", int'(state), e.st);
        checkField("imem_timeout", int'(imem_timeout), e.timeout);
        checkField("redirect_count", int'(redirect_count), e.redir);
    endtask

    // Monitor: one expectation per cycle, sampled half a period after the inputs settle
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput(e);
            cycleNum++;
        end
    end

    initial begin
        bit r, imr, st, bv, bt, ba, ban, jv;
        modelReset();
        cR = 0; cImr = 1; cSt = 0; cBv = 0; cBt = 0; cBa = 0; cBan = 0; cJv = 0;

        repeat (2) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (4) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 1, 1, 1, 1, 0);
        applyStimulus(1, 1, 0, 1, 1, 0, 1, 0);
        repeat (3) applyStimulus(1, 1, 1, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 1, 0, 0, 0);
        repeat (5) applyStimulus(1, 0, 0, 1, 1, 0, 0, 0);
        repeat (2) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 1, 0, 1, 1);
        repeat (CNT_MAX + 2) applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                repeat (5) applyStimulus(1, 0, 0, 1'($urandom), 1'($urandom), 0, 0, 1'($urandom));
            end
            r   = ($urandom_range(0, 99) != 0);
            imr = ($urandom_range(0, 4) != 0);
            st  = ($urandom_range(0, 4) == 0);
            bv  = 1'($urandom);
            bt  = 1'($urandom);
            ba  = ($urandom_range(0, 3) == 0);
            ban = 1'($urandom);
            jv  = ($urandom_range(0, 5) == 0);
            applyStimulus(r, imr, st, bv, bt, ba, ban, jv);
        end

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        checkField("queue_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
